// File: rtl/imm_prefix_extender.sv
// Immediate-constant unit: sign/zero-extends an immediate field to DATA_W.
// Up to MAX_PREFIX prefix fields may precede the final field to build a wide constant.
//
// Ports:
//   clk, rst_n            clock (rising edge), async active-low reset
//   in_valid/in_ready     field handshake
//   in_imm                immediate field
//   in_prefix             1 = prefix field, 0 = final field
//   in_cs                 1 = sign-extend, 0 = zero-extend (final field only)
//   flush                 drops any partial constant
//   out_valid/out_ready   result handshake
//   out_data              extended constant
//   out_err               too many prefixes were given for this constant
module imm_prefix_extender #(
  parameter int DATA_W     = 8,
  parameter int IMM_W      = 6,
  parameter int MAX_PREFIX = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [IMM_W-1:0]  in_imm,
  input  logic              in_prefix,
  input  logic              in_cs,
  input  logic              flush,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic              out_err
);

  localparam int ACC_W = IMM_W * (MAX_PREFIX + 1);
  localparam int CNT_W = (MAX_PREFIX < 2) ? 1 : $clog2(MAX_PREFIX + 1);
  localparam int EXT_W = (ACC_W > DATA_W) ? ACC_W : DATA_W;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_PREFIX);

  logic [ACC_W-1:0] acc;
  logic [CNT_W-1:0] cnt;
  logic             err_pend;

  logic             accept;
  logic             take_pre;
  logic             take_ovf;
  logic             take_fin;
  logic [ACC_W-1:0] v;
  logic [EXT_W-1:0] ext;
  logic             sign;
  int               t;

  // rst_n is folded in so the input side stays closed during reset.
  assign in_ready = rst_n && !flush && (!out_valid || out_ready);

  assign accept   = in_valid && in_ready;
  assign take_pre = accept && in_prefix && (cnt != CNT_MAX);
  assign take_ovf = accept && in_prefix && (cnt == CNT_MAX);
  assign take_fin = accept && !in_prefix;

  // Bits of acc above cnt*IMM_W are always zero, so the upper
  // IMM_W bits never carry information and can be shifted out.
  assign v = {acc[ACC_W-IMM_W-1:0], in_imm};

  always_comb begin
    t    = IMM_W * (int'(cnt) + 1);
    sign = 1'b0;
    for (int k = 0; k <= MAX_PREFIX; k++) begin
      if (cnt == CNT_W'(k)) sign = v[IMM_W*(k+1)-1];
    end
    sign = sign && in_cs;
    ext  = '0;
    ext[ACC_W-1:0] = v;
    for (int i = 0; i < EXT_W; i++) begin
      if (i >= t) ext[i] = sign;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc      <= '0;
      cnt      <= '0;
      err_pend <= 1'b0;
    end else begin
      unique case (1'b1)
        flush: begin
          acc      <= '0;
          cnt      <= '0;
          err_pend <= 1'b0;
        end
        take_pre: begin
          acc <= v;
          cnt <= cnt + CNT_W'(1);
        end
        take_ovf: begin
          err_pend <= 1'b1;
        end
        take_fin: begin
          acc      <= '0;
          cnt      <= '0;
          err_pend <= 1'b0;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_err   <= 1'b0;
    end else if (take_fin) begin
      out_valid <= 1'b1;
      out_data  <= ext[DATA_W-1:0];
      out_err   <= err_pend;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_imm_prefix_extender.sv
// Directed bench for imm_prefix_extender.
// Two instances (DATA_W=8 and DATA_W=16) share one input stream.
module tb_imm_prefix_extender;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic [5:0]  in_imm;
  logic        in_prefix;
  logic        in_cs;
  logic        flush;
  logic        out_ready;

  logic        r8;
  logic        v8;
  logic [7:0]  d8;
  logic        e8;
  logic        r16;
  logic        v16;
  logic [15:0] d16;
  logic        e16;

  int checks;
  int errors;

  imm_prefix_extender #(.DATA_W(8), .IMM_W(6), .MAX_PREFIX(2)) u8 (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(r8),
    .in_imm(in_imm), .in_prefix(in_prefix), .in_cs(in_cs),
    .flush(flush),
    .out_valid(v8), .out_ready(out_ready),
    .out_data(d8), .out_err(e8)
  );

  imm_prefix_extender #(.DATA_W(16), .IMM_W(6), .MAX_PREFIX(2)) u16 (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(r16),
    .in_imm(in_imm), .in_prefix(in_prefix), .in_cs(in_cs),
    .flush(flush),
    .out_valid(v16), .out_ready(out_ready),
    .out_data(d16), .out_err(e16)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input string tag, input logic [5:0] imm,
                      input logic pre, input logic cs);
    in_valid  = 1'b1;
    in_imm    = imm;
    in_prefix = pre;
    in_cs     = cs;
    #1;
    chk({tag, "_rdy"}, {31'b0, r8}, 32'd1);
    step();
    in_valid = 1'b0;
  endtask

  task automatic out_chk(input string tag, input logic [7:0] x8,
                         input logic [15:0] x16, input logic err);
    chk({tag, "_v8"}, {31'b0, v8}, 32'd1);
    chk({tag, "_v16"}, {31'b0, v16}, 32'd1);
    chk({tag, "_d8"}, {24'b0, d8}, {24'b0, x8});
    chk({tag, "_d16"}, {16'b0, d16}, {16'b0, x16});
    chk({tag, "_e8"}, {31'b0, e8}, {31'b0, err});
    chk({tag, "_e16"}, {31'b0, e16}, {31'b0, err});
  endtask

  initial begin
    checks    = 0;
    errors    = 0;
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_imm    = '0;
    in_prefix = 1'b0;
    in_cs     = 1'b0;
    flush     = 1'b0;
    out_ready = 1'b1;

    #3;
    chk("rst_rdy8", {31'b0, r8}, 32'd0);
    chk("rst_rdy16", {31'b0, r16}, 32'd0);
    chk("rst_v8", {31'b0, v8}, 32'd0);
    chk("rst_d16", {16'b0, d16}, 32'd0);
    chk("rst_e8", {31'b0, e8}, 32'd0);
    #9 rst_n = 1'b1;
    step();
    chk("post_rst_rdy", {31'b0, r8}, 32'd1);

    send("leg_a", 6'h20, 1'b0, 1'b1);
    out_chk("leg_a", 8'hE0, 16'hFFE0, 1'b0);
    send("leg_b", 6'h20, 1'b0, 1'b0);
    out_chk("leg_b", 8'h20, 16'h0020, 1'b0);
    send("leg_c", 6'h1F, 1'b0, 1'b1);
    out_chk("leg_c", 8'h1F, 16'h001F, 1'b0);

    send("ch1_p", 6'h2A, 1'b1, 1'b1);
    chk("ch1_no_out", {31'b0, v16}, 32'd0);
    send("ch1_f", 6'h15, 1'b0, 1'b1);
    out_chk("ch1", 8'h95, 16'hFA95, 1'b0);
    send("ch2_p", 6'h2A, 1'b1, 1'b0);
    chk("ch2_no_out", {31'b0, v16}, 32'd0);
    send("ch2_f", 6'h15, 1'b0, 1'b0);
    out_chk("ch2", 8'h95, 16'h0A95, 1'b0);

    send("tr_p", 6'h03, 1'b1, 1'b0);
    send("tr_f", 6'h3F, 1'b0, 1'b0);
    out_chk("trunc", 8'hFF, 16'h00FF, 1'b0);

    send("bp_f", 6'h20, 1'b0, 1'b0);
    out_chk("bp_first", 8'h20, 16'h0020, 1'b0);
    out_ready = 1'b0;
    step();
    out_chk("bp_hold", 8'h20, 16'h0020, 1'b0);
    chk("bp_rdy_low", {31'b0, r8}, 32'd0);
    in_valid  = 1'b1;
    in_imm    = 6'h1F;
    in_prefix = 1'b0;
    in_cs     = 1'b1;
    step();
    out_chk("bp_stall", 8'h20, 16'h0020, 1'b0);
    out_ready = 1'b1;
    #1;
    chk("bp_rdy_up", {31'b0, r8}, 32'd1);
    step();
    in_valid = 1'b0;
    out_chk("bp_reload", 8'h1F, 16'h001F, 1'b0);
    step();
    chk("bp_drain", {31'b0, v8}, 32'd0);

    send("ov_p1", 6'h01, 1'b1, 1'b0);
    send("ov_p2", 6'h02, 1'b1, 1'b0);
    send("ov_p3", 6'h03, 1'b1, 1'b0);
    send("ov_f", 6'h04, 1'b0, 1'b0);
    out_chk("ovf", 8'h84, 16'h1084, 1'b1);
    send("ov_next", 6'h05, 1'b0, 1'b0);
    out_chk("ovf_next", 8'h05, 16'h0005, 1'b0);

    send("fl_p", 6'h3F, 1'b1, 1'b1);
    flush     = 1'b1;
    in_valid  = 1'b1;
    in_imm    = 6'h3F;
    in_prefix = 1'b1;
    #1;
    chk("fl_rdy", {31'b0, r8}, 32'd0);
    step();
    flush    = 1'b0;
    in_valid = 1'b0;
    send("fl_f", 6'h05, 1'b0, 1'b1);
    out_chk("flush", 8'h05, 16'h0005, 1'b0);

    send("rs_f", 6'h0A, 1'b0, 1'b0);
    out_ready = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    chk("rs_v8", {31'b0, v8}, 32'd0);
    chk("rs_v16", {31'b0, v16}, 32'd0);
    chk("rs_d8", {24'b0, d8}, 32'd0);
    chk("rs_rdy", {31'b0, r8}, 32'd0);
    out_ready = 1'b1;
    step();
    rst_n = 1'b1;
    #1;
    chk("rs_rdy_rel", {31'b0, r8}, 32'd1);
    step();
    send("ra_p", 6'h3F, 1'b1, 1'b1);
    #2 rst_n = 1'b0;
    #1;
    chk("ra_rdy", {31'b0, r8}, 32'd0);
    step();
    rst_n = 1'b1;
    step();
    send("ra_f", 6'h05, 1'b0, 1'b1);
    out_chk("rst_accum", 8'h05, 16'h0005, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
